// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and the decoder that consumes its output.
package fetch_pkg;

   // Fetch sequencer states, shared so a later pipelined core can reuse the encoding.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      HALT = 3'd4
   } fetch_state_t;

   // addi x0, x0, 0 -- shown to decode before the first real fetch completes.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Boot address used when the top-level does not override it.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Major opcodes the decoder reads from instr[6:0].
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Instruction addresses must be word aligned; only the two low bits matter.
   function automatic logic is_word_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC arithmetic: sequential or PC-relative target, plus alignment check.
module next_pc_calc
   import fetch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm_ext,
   input  logic            PCSrc,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned
);

   // Select the target and flag any address that is not word aligned; sums wrap silently.
   always_comb begin
      next_pc    = pc + XLEN'(4);
      misaligned = 1'b0;
      if (PCSrc) begin
         next_pc = pc + imm_ext;
      end
      misaligned = !is_word_aligned(next_pc[1:0]);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a valid/ready request and
// valid response, holds the instruction for execution until it retires.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   input  logic            retire,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] imm_ext,
   output logic            fetch_fault
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] next_pc;
   logic            next_misaligned;
   logic            capture_rsp;
   logic            retire_hold;

   next_pc_calc #(
      .XLEN (XLEN)
   ) u_next_pc_calc (
      .pc         (pc),
      .imm_ext    (imm_ext),
      .PCSrc      (PCSrc),
      .next_pc    (next_pc),
      .misaligned (next_misaligned)
   );

   // Responses only count while waiting and retires only while holding; anything else is stray.
   always_comb begin
      capture_rsp = (state == WAIT) && imem_rsp_valid;
      retire_hold = (state == HOLD) && retire;
   end

   // State register; reset drops any in-flight request so a late response lands in IDLE/REQ and is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the state-decoded strobes.
   always_comb begin
      state_next     = state;
      imem_req_valid = 1'b0;
      instr_valid    = 1'b0;
      case (state)
         IDLE: begin
            state_next = REQ;
         end
         REQ: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (retire) begin
               state_next = next_misaligned ? HALT : REQ;
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Architectural registers: PC moves only on a good retire, instr only on a captured response,
   // and a misaligned target freezes the PC and latches the sticky fault.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         instr       <= XLEN'(NOP_INSTR);
         fetch_fault <= 1'b0;
      end else begin
         if (capture_rsp) begin
            instr <= imem_rsp_data;
         end
         if (retire_hold) begin
            if (next_misaligned) begin
               fetch_fault <= 1'b1;
            end else begin
               pc <= next_pc;
            end
         end
      end
   end

   // The request address is the PC itself, so it stays stable under backpressure.
   always_comb begin
      imem_addr = pc;
      pc_plus4  = pc + XLEN'(4);
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of fetch transactions plus reset corner cases.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire;
   logic        PCSrc;
   logic [31:0] imm_ext;
   logic        fetch_fault;

   typedef struct {
      int          ready_wait;
      int          rsp_wait;
      int          retire_wait;
      bit          stray;
      bit          pcsrc;
      logic [31:0] imm;
      logic [31:0] exp_next;
      bit          exp_fault;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   vec_t        vecs [8];
   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] cur_pc;
   logic [31:0] last_instr;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .retire         (retire),
      .PCSrc          (PCSrc),
      .imm_ext        (imm_ext),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a << 12) | 32'h0000_0033;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full fetch/execute/retire transaction, starting with the DUT in REQ at cur_pc.
   task automatic applyStimulus(input vec_t v);
      logic [31:0] accept_addr;
      exp_t        e;
      checkOutput("req_valid_in_req", imem_req_valid, 1);
      checkOutput("req_addr", imem_addr, cur_pc);
      checkOutput("pc_plus4", pc_plus4, cur_pc + 32'd4);
      for (int i = 0; i < v.ready_wait; i++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = v.stray;
         imem_rsp_data  = 32'hDEAD_BEEF;
         tick();
         checkOutput("backpressure_valid", imem_req_valid, 1);
         checkOutput("backpressure_addr", imem_addr, cur_pc);
         checkOutput("stray_rsp_instr", instr, last_instr);
      end
      imem_req_ready = 1'b1;
      imem_rsp_valid = v.stray;
      imem_rsp_data  = 32'hDEAD_BEEF;
      accept_addr    = imem_addr;
      tick();
      sb.push_back('{addr: cur_pc, data: mem_word(cur_pc)});
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      checkOutput("wait_no_req", imem_req_valid, 0);
      checkOutput("coincident_rsp_ignored", instr, last_instr);
      checkOutput("wait_instr_valid", instr_valid, 0);
      for (int i = 0; i < v.rsp_wait; i++) begin
         if (v.stray && i == 0) begin
            retire  = 1'b1;
            PCSrc   = 1'b1;
            imm_ext = 32'h0000_0040;
         end
         tick();
         retire  = 1'b0;
         PCSrc   = 1'b0;
         imm_ext = 32'h0;
         checkOutput("wait_pc_stable", pc, cur_pc);
         checkOutput("wait_instr_stable", instr, last_instr);
         checkOutput("wait_instr_valid_low", instr_valid, 0);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(accept_addr);
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      checks++;
      if (!instr_valid) begin
         errors++;
         $display("[TB] FAIL instr_valid_rise: got 0 expected 1");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("sb_instr", instr, e.data);
         checkOutput("sb_pc", pc, e.addr);
      end
      last_instr = mem_word(cur_pc);
      for (int i = 0; i < v.retire_wait; i++) begin
         PCSrc   = 1'b1;
         imm_ext = 32'h0000_0003;
         tick();
         checkOutput("hold_valid", instr_valid, 1);
         checkOutput("hold_pc", pc, cur_pc);
      end
      retire  = 1'b1;
      PCSrc   = v.pcsrc;
      imm_ext = v.imm;
      tick();
      retire  = 1'b0;
      PCSrc   = 1'b0;
      imm_ext = 32'h0;
      checkOutput("valid_falls", instr_valid, 0);
      checkOutput("retire_pc", pc, v.exp_next);
      checkOutput("retire_fault", fetch_fault, v.exp_fault);
      checkOutput("next_req_valid", imem_req_valid, !v.exp_fault);
      checkOutput("next_addr", imem_addr, v.exp_next);
      if (v.exp_fault) begin
         for (int i = 0; i < 4; i++) begin
            retire         = 1'b1;
            imem_req_ready = 1'b1;
            tick();
            checkOutput("halt_no_req", imem_req_valid, 0);
            checkOutput("halt_fault", fetch_fault, 1);
            checkOutput("halt_pc", pc, cur_pc);
            checkOutput("halt_instr_valid", instr_valid, 0);
         end
         retire         = 1'b0;
         imem_req_ready = 1'b0;
      end
      cur_pc = v.exp_next;
   endtask

   initial begin
      vecs[0] = '{0, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
      vecs[1] = '{0, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
      vecs[2] = '{0, 0, 0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0010, 1'b0};
      vecs[3] = '{0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008, 1'b0};
      vecs[4] = '{4, 0, 0, 1'b0, 1'b1, 32'h0000_0018, 32'h0000_0020, 1'b0};
      vecs[5] = '{1, 2, 1, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0024, 1'b0};
      vecs[6] = '{0, 1, 2, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0020, 1'b0};
      vecs[7] = '{0, 0, 0, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_0020, 1'b1};

      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      retire         = 1'b0;
      PCSrc          = 1'b0;
      imm_ext        = 32'h0;
      tick();
      tick();
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_instr", instr, 32'h0000_0013);
      checkOutput("rst_instr_valid", instr_valid, 0);
      checkOutput("rst_req_valid", imem_req_valid, 0);
      checkOutput("rst_fault", fetch_fault, 0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_pc_plus4", pc_plus4, 32'h4);
      rst = 1'b0;
      tick();
      cur_pc     = 32'h0;
      last_instr = 32'h0000_0013;
      for (int k = 0; k < 8; k++) begin
         $display("[TB] vector %0d at pc %h", k, cur_pc);
         applyStimulus(vecs[k]);
      end

      // Reset out of HALT, fetch one word, then reset in the middle of the next WAIT.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      checkOutput("halt_reset_fault", fetch_fault, 0);
      checkOutput("halt_reset_pc", pc, 32'h0);
      tick();
      cur_pc     = 32'h0;
      last_instr = 32'h0000_0013;
      applyStimulus(vecs[0]);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midwait_pc", pc, 32'h0);
      checkOutput("midwait_instr", instr, 32'h0000_0013);
      checkOutput("midwait_instr_valid", instr_valid, 0);
      checkOutput("midwait_req_valid", imem_req_valid, 0);
      tick();
      rst            = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(32'h4);
      tick();
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      checkOutput("late_rsp_instr", instr, 32'h0000_0013);
      checkOutput("late_rsp_instr_valid", instr_valid, 0);
      checkOutput("late_rsp_req_valid", imem_req_valid, 1);
      checkOutput("late_rsp_addr", imem_addr, 32'h0);
      sb.delete();
      cur_pc     = 32'h0;
      last_instr = 32'h0000_0013;
      applyStimulus(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
